// File: rtl/mem_stage_if.sv
// Execute -> memory -> write-back handshake bundle for mem_stage.
// The slave modport is the stage; the master side is execute, data memory and write-back.
interface mem_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest_reg;
    logic        ex_reg_write;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest_reg;
    logic        wb_reg_write;
    logic        wb_addr_err;
    logic        wb_bus_err;

    modport slave (
        input  ex_valid, ex_opcode, ex_alu_result, ex_store_data,
        input  ex_dest_reg, ex_reg_write, dmem_rdata, dmem_ack,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output wb_valid, wb_data, wb_dest_reg, wb_reg_write,
        output wb_addr_err, wb_bus_err
    );

    modport master (
        output ex_valid, ex_opcode, ex_alu_result, ex_store_data,
        output ex_dest_reg, ex_reg_write, dmem_rdata, dmem_ack,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  wb_valid, wb_data, wb_dest_reg, wb_reg_write,
        input  wb_addr_err, wb_bus_err
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: LW/SW over a req/ack data bus, pass-through otherwise.
// Define MEM_STAGE_TIMEOUT_EN to add the watchdog that aborts unacknowledged requests.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_stage_if.slave bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_ACK = 1'b1;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT_CYCLES must be in 2..255");
    end

    logic [0:0]  r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_dest;
    logic        r_rw;
    logic        r_wb_valid;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_dest;
    logic        r_wb_rw;
    logic        r_wb_aerr;
    logic        r_wb_berr;

    logic w_idle;
    logic w_acc;
    logic w_mem;
    logic w_mis;
    logic w_done;
    logic w_to;

    assign w_idle = (r_state == IDLE);
    assign w_acc  = bus.ex_valid && w_idle;
    assign w_mem  = (bus.ex_opcode == OP_LW) || (bus.ex_opcode == OP_SW);
    assign w_mis  = (bus.ex_alu_result[1:0] != 2'b00);
    assign w_done = !w_idle && bus.dmem_ack;

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0] r_wdog;

    // Ack on the expiry edge is excluded so a late ack still completes.
    assign w_to = !w_idle && !bus.dmem_ack &&
                  (r_wdog == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= 8'd0;
        end else if (w_acc && w_mem && !w_mis) begin
            r_wdog <= 8'd0;
        end else if (!w_idle && !bus.dmem_ack) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_dest     <= 5'd0;
            r_rw       <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= 32'd0;
            r_wb_dest  <= 5'd0;
            r_wb_rw    <= 1'b0;
            r_wb_aerr  <= 1'b0;
            r_wb_berr  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_aerr  <= 1'b0;
            r_wb_berr  <= 1'b0;
            unique case (1'b1)
                w_acc && !w_mem: begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= bus.ex_alu_result;
                    r_wb_dest  <= bus.ex_dest_reg;
                    r_wb_rw    <= bus.ex_reg_write;
                end
                w_acc && w_mem && w_mis: begin
                    r_wb_valid <= 1'b1;
                    r_wb_aerr  <= 1'b1;
                    r_wb_data  <= bus.ex_alu_result;
                    r_wb_dest  <= bus.ex_dest_reg;
                    r_wb_rw    <= 1'b0;
                end
                w_acc && w_mem && !w_mis: begin
                    r_state <= WAIT_ACK;
                    r_req   <= 1'b1;
                    r_we    <= (bus.ex_opcode == OP_SW);
                    r_addr  <= bus.ex_alu_result;
                    r_wdata <= bus.ex_store_data;
                    r_dest  <= bus.ex_dest_reg;
                    r_rw    <= bus.ex_reg_write;
                end
                w_done: begin
                    r_state    <= IDLE;
                    r_req      <= 1'b0;
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= r_we ? r_addr : bus.dmem_rdata;
                    r_wb_dest  <= r_dest;
                    r_wb_rw    <= r_we ? 1'b0 : r_rw;
                end
                w_to: begin
                    r_state    <= IDLE;
                    r_req      <= 1'b0;
                    r_wb_valid <= 1'b1;
                    r_wb_berr  <= 1'b1;
                    r_wb_data  <= r_addr;
                    r_wb_dest  <= r_dest;
                    r_wb_rw    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ex_ready     = w_idle;
    assign bus.dmem_req     = r_req;
    assign bus.dmem_we      = r_we;
    assign bus.dmem_addr    = r_addr;
    assign bus.dmem_wdata   = r_wdata;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_dest_reg  = r_wb_dest;
    assign bus.wb_reg_write = r_wb_rw;
    assign bus.wb_addr_err  = r_wb_aerr;
    assign bus.wb_bus_err   = r_wb_berr;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic against a
// transaction-level model; honours MEM_STAGE_TIMEOUT_EN.
module tb_mem_stage;
    localparam int unsigned TO = 4;
`ifdef MEM_STAGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mem_stage_if bus();

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int dly_mode = -1;
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Data memory: acks after a chosen delay, random ack noise while idle.
    int  m_cnt;
    bit  m_in = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst_n || !bus.dmem_req) begin
            m_in = 1'b0;
            bus.dmem_ack = rst_n && ($urandom_range(0, 3) == 0);
            bus.dmem_rdata = $urandom;
        end else begin
            if (!m_in) begin
                m_in = 1'b1;
                m_cnt = (dly_mode < 0) ? int'($urandom_range(0, 5)) : dly_mode;
            end
            if (m_cnt == 0) begin
                bus.dmem_ack = 1'b1;
                if (bus.dmem_we) mem[bus.dmem_addr] = bus.dmem_wdata;
                bus.dmem_rdata = mem.exists(bus.dmem_addr) ?
                                 mem[bus.dmem_addr] : ~bus.dmem_addr;
                m_in = 1'b0;
            end else begin
                bus.dmem_ack = 1'b0;
                bus.dmem_rdata = $urandom;
                m_cnt--;
            end
        end
    end

    // Transaction-level model: one outstanding access, one pending completion.
    bit          mb = 1'b0;
    int          mw;
    logic [31:0] ma, mwd;
    bit          mwe, mrw;
    logic [4:0]  md;
    bit          ev = 1'b0;
    logic [31:0] ed;
    logic [4:0]  edst;
    bit          erw, eae, ebe;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req", 32'(bus.dmem_req), 0);
            chk("rst_addr", bus.dmem_addr, 0);
            chk("rst_wbv", 32'(bus.wb_valid), 0);
            chk("rst_wbdata", bus.wb_data, 0);
            chk("rst_wbrw", 32'(bus.wb_reg_write), 0);
            chk("rst_ready", 32'(bus.ex_ready), 1);
            mb = 1'b0;
            ev = 1'b0;
        end else begin
            chk("ex_ready", 32'(bus.ex_ready), 32'(!mb));
            chk("dmem_req", 32'(bus.dmem_req), 32'(mb));
            if (mb) begin
                chk("dmem_addr", bus.dmem_addr, ma);
                chk("dmem_we", 32'(bus.dmem_we), 32'(mwe));
                chk("dmem_wdata", bus.dmem_wdata, mwd);
            end
            chk("wb_valid", 32'(bus.wb_valid), 32'(ev));
            if (ev) begin
                chk("wb_data", bus.wb_data, ed);
                chk("wb_dest", 32'(bus.wb_dest_reg), 32'(edst));
                chk("wb_rw", 32'(bus.wb_reg_write), 32'(erw));
            end
            chk("wb_aerr", 32'(bus.wb_addr_err), 32'(ev && eae));
            chk("wb_berr", 32'(bus.wb_bus_err), 32'(ev && ebe));
            ev = 1'b0;
            if (mb) begin
                if (bus.dmem_ack) begin
                    ev = 1'b1; ed = mwe ? ma : bus.dmem_rdata; edst = md;
                    erw = mwe ? 1'b0 : mrw; eae = 1'b0; ebe = 1'b0; mb = 1'b0;
                end else if (TO_EN && mw == int'(TO) - 1) begin
                    ev = 1'b1; ed = ma; edst = md;
                    erw = 1'b0; eae = 1'b0; ebe = 1'b1; mb = 1'b0;
                end else begin
                    mw++;
                end
            end else if (bus.ex_valid) begin
                edst = bus.ex_dest_reg;
                if (bus.ex_opcode != LW && bus.ex_opcode != SW) begin
                    ev = 1'b1; ed = bus.ex_alu_result;
                    erw = bus.ex_reg_write; eae = 1'b0; ebe = 1'b0;
                end else if (bus.ex_alu_result[1:0] != 2'b00) begin
                    ev = 1'b1; ed = bus.ex_alu_result;
                    erw = 1'b0; eae = 1'b1; ebe = 1'b0;
                end else begin
                    mb = 1'b1; mw = 0; ma = bus.ex_alu_result;
                    mwe = (bus.ex_opcode == SW); mwd = bus.ex_store_data;
                    md = bus.ex_dest_reg; mrw = bus.ex_reg_write;
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [5:0] op,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] dst, input bit rw);
        bus.ex_valid = v;
        bus.ex_opcode = op;
        bus.ex_alu_result = alu;
        bus.ex_store_data = sd;
        bus.ex_dest_reg = dst;
        bus.ex_reg_write = rw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] alu;
        drive(0, 6'h00, 0, 0, 0, 0);
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Pass-through back-to-back
        step();
        drive(1, 6'h09, 32'h10, 0, 5'd5, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) drive(0, 6'h00, 0, 0, 0, 0);
            @(negedge clk);
            chk("pt_wbv", 32'(bus.wb_valid), 1);
            chk("pt_data", bus.wb_data, 32'h10);
            chk("pt_ready", 32'(bus.ex_ready), 1);
            chk("pt_req", 32'(bus.dmem_req), 0);
        end

        // LW with same-cycle ack
        mem[32'h100] = 32'hDEADBEEF;
        dly_mode = 0;
        step();
        drive(1, LW, 32'h100, 0, 5'd7, 1);
        step();
        drive(0, 6'h00, 0, 0, 0, 0);
        @(negedge clk);
        chk("lw_ready_low", 32'(bus.ex_ready), 0);
        chk("lw_req", 32'(bus.dmem_req), 1);
        step();
        @(negedge clk);
        chk("lw_wbv", 32'(bus.wb_valid), 1);
        chk("lw_data", bus.wb_data, 32'hDEADBEEF);
        chk("lw_rw", 32'(bus.wb_reg_write), 1);
        chk("lw_ready", 32'(bus.ex_ready), 1);

        // SW with 3-cycle ack delay, next op held valid meanwhile
        dly_mode = 3;
        step();
        drive(1, SW, 32'h204, 32'hCAFEF00D, 5'd9, 0);
        step();
        drive(1, 6'h0F, 32'h1234, 0, 5'd3, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sw_req", 32'(bus.dmem_req), 1);
            chk("sw_we", 32'(bus.dmem_we), 1);
            chk("sw_addr", bus.dmem_addr, 32'h204);
            chk("sw_wdata", bus.dmem_wdata, 32'hCAFEF00D);
            chk("sw_ready", 32'(bus.ex_ready), 0);
            step();
        end
        @(negedge clk);
        chk("sw_wbv", 32'(bus.wb_valid), 1);
        chk("sw_rw", 32'(bus.wb_reg_write), 0);
        chk("sw_data", bus.wb_data, 32'h204);
        step();
        drive(0, 6'h00, 0, 0, 0, 0);
        @(negedge clk);
        chk("held_wbv", 32'(bus.wb_valid), 1);
        chk("held_data", bus.wb_data, 32'h1234);

        // Misaligned load
        step();
        drive(1, LW, 32'h102, 0, 5'd4, 1);
        step();
        drive(0, 6'h00, 0, 0, 0, 0);
        @(negedge clk);
        chk("mis_wbv", 32'(bus.wb_valid), 1);
        chk("mis_aerr", 32'(bus.wb_addr_err), 1);
        chk("mis_data", bus.wb_data, 32'h102);
        chk("mis_rw", 32'(bus.wb_reg_write), 0);
        chk("mis_req", 32'(bus.dmem_req), 0);

        // Reset during WAIT_ACK
        dly_mode = 50;
        step();
        drive(1, LW, 32'h300, 0, 5'd6, 1);
        step();
        drive(0, 6'h00, 0, 0, 0, 0);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_req", 32'(bus.dmem_req), 0);
        chk("mrst_wbv", 32'(bus.wb_valid), 0);
        chk("mrst_ready", 32'(bus.ex_ready), 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        dly_mode = -1;
        step();
        drive(1, 6'h08, 32'hABC, 0, 5'd2, 1);
        step();
        drive(0, 6'h00, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_wbv", 32'(bus.wb_valid), 1);
        chk("post_rst_data", bus.wb_data, 32'hABC);

`ifdef MEM_STAGE_TIMEOUT_EN
        // Watchdog expiry, then ack on the final allowed cycle
        for (int k = 0; k < 2; k++) begin
            dly_mode = (k == 0) ? 100 : 3;
            step();
            drive(1, LW, 32'h400, 0, 5'd8, 1);
            step();
            drive(0, 6'h00, 0, 0, 0, 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("to_req", 32'(bus.dmem_req), 1);
                chk("to_wbv_low", 32'(bus.wb_valid), 0);
                step();
            end
            @(negedge clk);
            chk("to_wbv", 32'(bus.wb_valid), 1);
            chk("to_berr", 32'(bus.wb_bus_err), (k == 0) ? 1 : 0);
            chk("to_rw", 32'(bus.wb_reg_write), (k == 0) ? 0 : 1);
            chk("to_data", bus.wb_data, (k == 0) ? 32'h400 : 32'hFFFF_FBFF);
        end
        dly_mode = -1;
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            case ($urandom_range(0, 3))
                0: op = LW;
                1: op = SW;
                default: begin
                    op = 6'($urandom);
                    if (op == LW || op == SW) op = 6'h00;
                end
            endcase
            if (op == LW || op == SW)
                alu = (32'($urandom_range(0, 63)) << 2) |
                      (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
            else
                alu = $urandom;
            drive($urandom_range(0, 9) < 7, op, alu, $urandom,
                  5'($urandom), 1'($urandom));
        end
        step();
        drive(0, 6'h00, 0, 0, 0, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drain_idle", 32'(bus.ex_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
